// File: rtl/panel_pkg.sv
// panel_pkg: shared FSM encoding and character constants for the panel text scheduler
package panel_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BLANK, COMMIT} state_t;
    localparam logic [7:0] CHAR_MIN = 8'h20;
    localparam logic [7:0] CHAR_MAX = 8'h7E;
    localparam logic [7:0] FILL_DEFAULT = 8'h20;
    function automatic logic [7:0] sanitize(input logic [7:0] c, input logic [7:0] fill);
        return (c < CHAR_MIN || c > CHAR_MAX) ? fill : c;
    endfunction
endpackage

// File: rtl/panel_rr_arbiter.sv
// panel_rr_arbiter: two-way round-robin pick between requesters A and B
// ports: req_a/req_b requests, last (1 = B granted last), winner (1 = B wins)
module panel_rr_arbiter (
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic winner
);
    // B wins alone, or on a tie when A was the one served last
    assign winner = req_b & (~req_a | ~last);
endmodule

// File: rtl/panel_text_scheduler.sv
// panel_text_scheduler: arbitrates string updates and commits them only during vertical blanking
// ports: vga_clk/rst clock and sync reset, pos_y scan row, req_*/str_* requester inputs,
//        gnt_* capture pulses, panel_string committed text, busy not idle, done commit pulse
module panel_text_scheduler
    import panel_pkg::*;
#(
    parameter int         CHAR_COUNT = 13,
    parameter int         V_ACTIVE   = 480,
    parameter logic [7:0] FILL_CHAR  = FILL_DEFAULT
) (
    input  logic                    vga_clk,
    input  logic                    rst,
    input  logic [9:0]              pos_y,
    input  logic                    req_a,
    input  logic                    req_b,
    input  logic [8*CHAR_COUNT-1:0] str_a,
    input  logic [8*CHAR_COUNT-1:0] str_b,
    output logic                    gnt_a,
    output logic                    gnt_b,
    output logic [8*CHAR_COUNT-1:0] panel_string,
    output logic                    busy,
    output logic                    done
);
    localparam int IW = $clog2(CHAR_COUNT + 1);

    state_t                  state, state_n;
    logic [IW-1:0]           idx;
    logic                    win_b, last_b, arb_b;
    logic                    cur_req, last_byte, grant, commit;
    logic [8*CHAR_COUNT-1:0] src, shadow;
    logic [7:0]              byte_in;

    panel_rr_arbiter arb (.req_a(req_a), .req_b(req_b), .last(last_b), .winner(arb_b));

    always_comb begin
        src       = win_b ? str_b : str_a;
        cur_req   = win_b ? req_b : req_a;
        byte_in   = src[8*(CHAR_COUNT-1-int'(idx)) +: 8];
        last_byte = idx == IW'(CHAR_COUNT - 1);
        grant     = state == LOAD && cur_req && last_byte;
        commit    = state == COMMIT;
        busy      = state != IDLE;
        state_n   = state;
        unique case (state)
            IDLE:       state_n = (req_a | req_b) ? LOAD : IDLE;
            LOAD:       state_n = !cur_req ? IDLE : last_byte ? WAIT_BLANK : LOAD;
            WAIT_BLANK: state_n = (32'(pos_y) >= V_ACTIVE) ? COMMIT : WAIT_BLANK;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            win_b        <= 1'b0;
            last_b       <= 1'b1;
            gnt_a        <= 1'b0;
            gnt_b        <= 1'b0;
            done         <= 1'b0;
            shadow       <= {CHAR_COUNT{FILL_CHAR}};
            panel_string <= {CHAR_COUNT{FILL_CHAR}};
        end else begin
            state <= state_n;
            gnt_a <= grant & ~win_b;
            gnt_b <= grant & win_b;
            done  <= commit;
            if (state == IDLE) begin
                win_b <= arb_b;
                idx   <= '0;
            end
            // a dropped request aborts the load without touching the shadow further
            if (state == LOAD && cur_req) begin
                shadow[8*(CHAR_COUNT-1-int'(idx)) +: 8] <= sanitize(byte_in, FILL_CHAR);
                idx <= idx + 1'b1;
            end
            if (grant) last_b <= win_b;
            if (commit) panel_string <= shadow;
        end
    end
endmodule
